simd_mode_dispatch: RTL
=======================

Name: simd_mode_dispatch

Overview:
- Issue-side controller for the 64-lane unary SIMD array: accepts one operation request (mode, run length, per-lane operands) and drives the four function units (mac/div/exp/log).
- Registers operands, pulses a unit clear, enables exactly one unit for the requested number of bitstream cycles, then presents completion downstream.
- Drives the mode select of the output mux and holds it stable until the result is consumed.

Parameters:
- LANES, 64, number of SIMD lanes.
- DW, `MAC_BW, operand width per lane.
- LEN_W, 8, width of run-length field; a run is 1..2^LEN_W cycles.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_mode  input  2  0=mac, 1=div, 2=exp, 3=log.
- in_len  input  LEN_W  run cycles; 0 means 2^LEN_W.
- iA  input  DW x LANES  operand A per lane.
- iB  input  DW x LANES  operand B per lane.
- opA  output  DW x LANES  registered operand A to units.
- opB  output  DW x LANES  registered operand B to units.
- unit_clr  output  1  one-cycle clear pulse to all units.
- unit_en  output  4  one-hot enable; bit index = mode.
- mode_o  output  2  select for the result mux.
- out_valid  output  1  result ready.
- out_ready  input  1  downstream consumes the result.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset values: state=IDLE; opA, opB = 0; unit_clr=0; unit_en=0; mode_o=0; out_valid=0; busy=0; counter=0; in_ready=1 one gate delay after reset deasserts.
- in_ready = (state==IDLE), combinational from state only, never from in_valid.
- IDLE: on accept, latch iA, iB, in_mode, in_len; mode_o updates on the same edge; go to CLR.
- CLR (1 cycle):
  - unit_clr=1, unit_en=0.
  - Counter loads latched len; a len of 0 loads 0 and, by wrap, yields 2^LEN_W cycles.
  - Go to RUN.
- RUN:
  - unit_en[mode]=1, other bits 0.
  - Counter decrements each cycle, modulo 2^LEN_W.
  - When the counter equals 1 in the current cycle, this is the last RUN cycle; go to DONE. RUN therefore lasts exactly len cycles, or 2^LEN_W cycles for len=0.
- DONE:
  - out_valid=1, unit_en=0.
  - Hold until out_ready; on out_valid && out_ready, go to IDLE.
  - out_valid may stay high indefinitely; opA, opB and mode_o remain stable throughout.
- Latency: accept edge to first out_valid cycle = 1 (CLR) + len (RUN) cycles after the accept cycle. len=3 gives out_valid in the 5th cycle after the accept edge.
- mode_o and opA/opB change only on an accepted request; they keep their last value in IDLE.
- in_valid while busy: ignored and not latched; the requester must hold it (valid/ready rule). Inputs may change while in_valid=0.
- out_ready high while out_valid=0: no effect.
- Reset mid-operation: every register returns to its reset value asynchronously; no partial completion is reported.
- unit_en is never non-one-hot. unit_clr and unit_en are never high in the same cycle.

Optional Feature:
- Macro: SIMD_DISPATCH_PERF_CNT_EN.
- Defined: adds outputs perf_run_cyc[31:0] (counts RUN cycles, saturating at 2^32-1) and perf_ops[31:0] (counts DONE handshakes, wrapping). Both reset to 0 via rst_n.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package simd_dispatch_pkg:
  - mode_e enum: MODE_MAC=2'd0, MODE_DIV=2'd1, MODE_EXP=2'd2, MODE_LOG=2'd3. The encoding is shared with the result mux.
  - state_e enum: IDLE, CLR, RUN, DONE.
  - Operand lane array typedef using `MAC_BW from param_def.sv.
- One sub-module, dispatch_len_cnt: loadable down-counter with a last-cycle flag (load, dec, last). The FSM, operand registers and perf counters stay in the top module.

Test Plan:
- Reset, then an op with mode=2 (exp), len=3, iA[0]=8'h5A → unit_clr pulse at cycle 1, unit_en=4'b0100 for exactly 3 cycles, out_valid at cycle 5, mode_o=2 and opA[0]=8'h5A throughout.
- len=0 with LEN_W=8 → unit_en high for exactly 256 cycles, then out_valid.
- out_ready held low for 10 cycles in DONE → out_valid, mode_o and opA stay stable; a concurrent in_valid with mode=1 is not accepted (in_ready=0); it is accepted in the first cycle after out_ready=1 brings the FSM back to IDLE.
- Back-to-back ops mac, div, log (len=1 each), with out_ready tied high → unit_en sequence 0001, 0010, 1000, each 1 cycle; mode_o=0, 1, 3; 3 out_valid pulses.
- rst_n asserted in the 2nd RUN cycle of a len=5 op → all outputs go to reset values immediately; no out_valid; the next op runs normally.
- With SIMD_DISPATCH_PERF_CNT_EN defined, ops len=4 and len=2 → perf_run_cyc=6, perf_ops=2.

Source files
------------

// File: rtl/simd_dispatch_pkg.sv
// simd_dispatch_pkg
// Shared types for the SIMD issue-side dispatcher.
//   mode_e     : function unit select. The result mux uses the same encoding.
//   state_e    : dispatcher FSM states.
//   lane_vec_t : per-lane operand array, LANES_DEF lanes of `MAC_BW bits.
// `MAC_BW is normally provided by param_def.sv. It falls back to 8 when it is not defined.
`ifndef MAC_BW
`define MAC_BW 8
`endif

package simd_dispatch_pkg;

  localparam int LANES_DEF = 64;
  localparam int DW_DEF    = `MAC_BW;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    MODE_MAC = 2'd0,
    MODE_DIV = 2'd1,
    MODE_EXP = 2'd2,
    MODE_LOG = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    RUN,
    DONE
  } state_e;

  typedef logic [LANES_DEF-1:0][DW_DEF-1:0] lane_vec_t;

  // One-hot unit enable for a mode; bit index equals the mode encoding
  function automatic logic [3:0] mode_onehot(input mode_e m);
    return 4'b0001 << m;
  endfunction

endpackage

// File: rtl/dispatch_len_cnt.sv
// dispatch_len_cnt
// This is a loadable down-counter that sets a flag on the last cycle of a run.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over dec)
//   load_val   : run length; 0 wraps to give 2^W cycles
//   dec        : decrement by one, modulo 2^W
//   last       : counter currently equals 1
module dispatch_len_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] cnt;

  // Loading 0 makes the first decrement wrap to all-ones, so a zero length runs 2^W cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/simd_mode_dispatch.sv
// simd_mode_dispatch
// This is the issue-side controller for the unary SIMD array. It accepts one request at a time.
// It registers the operands and pulses a clear to the units. It then enables one function unit
// for the requested run length and holds the result valid until downstream takes it.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : request handshake; in_ready is high only while idle
//   in_mode, in_len       : unit select (mac/div/exp/log) and run length (0 = 2^LEN_W)
//   iA, iB                : per-lane operands, flattened LANES x DW
//   opA, opB              : registered operands to the units
//   unit_clr              : one-cycle clear to all units
//   unit_en               : one-hot unit enable, bit index = mode
//   mode_o                : result mux select, stable until the next accepted request
//   out_valid/out_ready   : completion handshake
//   busy                  : high in every state except idle
// Optional: when SIMD_DISPATCH_PERF_CNT_EN is defined, the module adds two outputs.
//   perf_run_cyc counts RUN cycles and saturates. perf_ops counts completions and wraps.
module simd_mode_dispatch
  import simd_dispatch_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mode,
  input  logic [LEN_W-1:0]      in_len,
  input  logic [LANES*DW-1:0]   iA,
  input  logic [LANES*DW-1:0]   iB,
  output logic [LANES*DW-1:0]   opA,
  output logic [LANES*DW-1:0]   opB,
  output logic                  unit_clr,
  output logic [3:0]            unit_en,
  output logic [1:0]            mode_o,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
`ifdef SIMD_DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_run_cyc,
  output logic [31:0]           perf_ops
`endif
);

  state_e              state_q, state_d;
  mode_e               mode_q;
  logic [LEN_W-1:0]    len_q;
  logic [LANES*DW-1:0] opa_q, opb_q;
  logic                accept;
  logic                cnt_last;

  assign accept = in_valid && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields are captured only on an accepted handshake, so they survive through idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_MAC;
      len_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
    end else if (accept) begin
      mode_q <= mode_e'(in_mode);
      len_q  <= in_len;
      opa_q  <= iA;
      opb_q  <= iB;
    end
  end

  // The counter loads during the clear cycle and counts down through RUN
  dispatch_len_cnt #(.W(LEN_W)) u_len_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_q == CLR),
    .load_val (len_q),
    .dec      (state_q == RUN),
    .last     (cnt_last)
  );

  // Next-state logic; all outputs decode from the current state only
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    unit_clr  = 1'b0;
    unit_en   = 4'b0000;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = CLR;
      end
      CLR: begin
        unit_clr = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        unit_en = mode_onehot(mode_q);
        if (cnt_last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign opA    = opa_q;
  assign opB    = opb_q;
  assign mode_o = mode_q;

`ifdef SIMD_DISPATCH_PERF_CNT_EN
  // The RUN-cycle count saturates so that long soaks still read the maximum. The op count wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_run_cyc <= '0;
      perf_ops     <= '0;
    end else begin
      if (state_q == RUN && perf_run_cyc != 32'hFFFF_FFFF) begin
        perf_run_cyc <= perf_run_cyc + 32'd1;
      end
      if (state_q == DONE && out_ready) begin
        perf_ops <= perf_ops + 32'd1;
      end
    end
  end
`endif

endmodule
